// File: rtl/traffic_pkg.sv
// Shared definitions for the junction light controller.
// - Default parameter values for road count, counter width and all-red length.
// - Phase state encoding (ST_ALL_RED, ST_GREEN, ST_YELLOW).
// - clamp_time: a programmed duration of 0 behaves as 1 cycle.
// - wrap_inc: cyclic road increment for an arbitrary road count.
package traffic_pkg;

    localparam int DEF_N_ROADS     = 4;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_ALL_RED_CYC = 2;

    typedef logic [1:0] state_t;

    localparam state_t ST_ALL_RED = 2'd0;
    localparam state_t ST_GREEN   = 2'd1;
    localparam state_t ST_YELLOW  = 2'd2;

    function automatic int unsigned clamp_time(input int unsigned t);
        return (t == 0) ? 1 : t;
    endfunction

    function automatic int unsigned wrap_inc(input int unsigned road, input int unsigned n);
        return (road + 1 >= n) ? 0 : road + 1;
    endfunction

endpackage

// File: rtl/rr_next_road.sv
// Cyclic priority search for the next road with a waiting vehicle.
// Ports:
//   sensor     in  vehicle-present flag per road
//   cur_road   in  road most recently served; the search starts just after it
//   next_road  out first road with sensor set, scanning cur_road+1, +2, ... cyclically
//   found      out high when any sensor is set (next_road is meaningless otherwise)
module rr_next_road
    import traffic_pkg::*;
#(
    parameter int N_ROADS = DEF_N_ROADS
) (
    input  logic [N_ROADS-1:0]         sensor,
    input  logic [$clog2(N_ROADS)-1:0] cur_road,
    output logic [$clog2(N_ROADS)-1:0] next_road,
    output logic                       found
);

    localparam int ROAD_W = $clog2(N_ROADS);

    logic [ROAD_W-1:0] idx;

    always_comb begin
        next_road = '0;
        found     = 1'b0;
        idx       = '0;
        // Walk from the farthest candidate back to the nearest so the nearest hit wins.
        // i == N_ROADS wraps to cur_road itself, the lowest-priority candidate.
        for (int i = N_ROADS; i >= 1; i--) begin
            idx = ROAD_W'((32'(cur_road) + 32'(i)) % 32'(N_ROADS));
            if (sensor[idx]) begin
                next_road = idx;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Traffic-phase sequencer for an N-road junction: GREEN -> YELLOW -> ALL_RED per served road,
// round-robin over roads with waiting vehicles, with emergency pre-emption.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   en            advance enable; low freezes all state including outputs
//   green_time    green length in cycles, sampled on GREEN entry (0 acts as 1)
//   yellow_time   yellow length in cycles, sampled on YELLOW entry (0 acts as 1)
//   sensor        vehicle-present flag per road
//   emerg_req     emergency request (level); emerg_road >= N_ROADS is ignored
//   emerg_road    road to serve on emergency
//   allow / warn  one-hot green / yellow for cur_road
//   all_red       high during the all-red clearance
//   cur_road      road currently or last served
//   phase_done    one-cycle pulse on the first ALL_RED cycle after a YELLOW
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int N_ROADS     = DEF_N_ROADS,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int ALL_RED_CYC = DEF_ALL_RED_CYC
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [CNT_W-1:0]           green_time,
    input  logic [CNT_W-1:0]           yellow_time,
    input  logic [N_ROADS-1:0]         sensor,
    input  logic                       emerg_req,
    input  logic [$clog2(N_ROADS)-1:0] emerg_road,
    output logic [N_ROADS-1:0]         allow,
    output logic [N_ROADS-1:0]         warn,
    output logic                       all_red,
    output logic [$clog2(N_ROADS)-1:0] cur_road,
    output logic                       phase_done
);

    localparam int               ROAD_W       = $clog2(N_ROADS);
    localparam logic [CNT_W-1:0] ALL_RED_LOAD = CNT_W'(ALL_RED_CYC - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ROAD_W-1:0]    road_q, road_d;
    logic [N_ROADS-1:0]   allow_q, allow_d;
    logic [N_ROADS-1:0]   warn_q, warn_d;
    logic                 all_red_q, all_red_d;
    logic                 done_q, done_d;

    logic                 emerg_ok;
    logic [ROAD_W-1:0]    rr_road;
    logic                 rr_found;
    logic [ROAD_W-1:0]    inc_road;
    logic [CNT_W-1:0]     green_load;
    logic [CNT_W-1:0]     yellow_load;
    logic [N_ROADS-1:0]   road_onehot;

    // When N_ROADS fills the index range every encoding is a valid road.
    if (N_ROADS == (1 << ROAD_W)) begin : g_full_range
        assign emerg_ok = emerg_req;
    end else begin : g_range_check
        assign emerg_ok = emerg_req && (emerg_road < ROAD_W'(N_ROADS));
    end

    rr_next_road #(
        .N_ROADS(N_ROADS)
    ) u_rr_next_road (
        .sensor    (sensor),
        .cur_road  (road_q),
        .next_road (rr_road),
        .found     (rr_found)
    );

    assign inc_road    = ROAD_W'(wrap_inc(32'(road_q), N_ROADS));
    assign green_load  = CNT_W'(clamp_time(32'(green_time)) - 1);
    assign yellow_load = CNT_W'(clamp_time(32'(yellow_time)) - 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        road_d  = road_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_ALL_RED: begin
                if (cnt_q == '0) begin
                    if (emerg_ok) begin
                        road_d = emerg_road;
                    end else if (rr_found) begin
                        road_d = rr_road;
                    end else begin
                        road_d = inc_road;
                    end
                    state_d = ST_GREEN;
                    cnt_d   = green_load;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GREEN: begin
                if (emerg_ok && (emerg_road == road_q)) begin
                    // Emergency vehicle on the served road: freeze the green.
                    cnt_d = cnt_q;
                end else if (emerg_ok || (cnt_q == '0)) begin
                    state_d = ST_YELLOW;
                    cnt_d   = yellow_load;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_YELLOW: begin
                if (cnt_q == '0) begin
                    state_d = ST_ALL_RED;
                    cnt_d   = ALL_RED_LOAD;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_ALL_RED;
                cnt_d   = ALL_RED_LOAD;
            end
        endcase

        road_onehot         = '0;
        road_onehot[road_d] = 1'b1;
        allow_d   = (state_d == ST_GREEN)  ? road_onehot : '0;
        warn_d    = (state_d == ST_YELLOW) ? road_onehot : '0;
        all_red_d = (state_d == ST_ALL_RED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_ALL_RED;
            cnt_q     <= ALL_RED_LOAD;
            road_q    <= ROAD_W'(N_ROADS - 1);
            allow_q   <= '0;
            warn_q    <= '0;
            all_red_q <= 1'b1;
            done_q    <= 1'b0;
        end else if (en) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            road_q    <= road_d;
            allow_q   <= allow_d;
            warn_q    <= warn_d;
            all_red_q <= all_red_d;
            done_q    <= done_d;
        end
    end

    assign allow      = allow_q;
    assign warn       = warn_q;
    assign all_red    = all_red_q;
    assign cur_road   = road_q;
    assign phase_done = done_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench: stimulus pushes expected output snapshots tagged with a cycle number,
// a negedge monitor pops and compares them as the DUT reaches that cycle.
// dut (N=4) carries the main scenarios; dut6 (N=6) covers emergency road range checks.
module tb_traffic_phase_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rst2, en;
    logic [7:0] green_time, yellow_time;

    logic [3:0] sensor;
    logic       emerg_req;
    logic [1:0] emerg_road;
    logic [3:0] allow, warn;
    logic       all_red, phase_done;
    logic [1:0] cur_road;

    logic [5:0] sensor2;
    logic       emerg_req2;
    logic [2:0] emerg_road2;
    logic [5:0] allow2, warn2;
    logic       all_red2, phase_done2;
    logic [2:0] cur_road2;

    traffic_phase_ctrl #(.N_ROADS(4), .CNT_W(8), .ALL_RED_CYC(2)) dut (
        .clk(clk), .rst(rst), .en(en), .green_time(green_time), .yellow_time(yellow_time),
        .sensor(sensor), .emerg_req(emerg_req), .emerg_road(emerg_road),
        .allow(allow), .warn(warn), .all_red(all_red), .cur_road(cur_road),
        .phase_done(phase_done)
    );

    traffic_phase_ctrl #(.N_ROADS(6), .CNT_W(8), .ALL_RED_CYC(2)) dut6 (
        .clk(clk), .rst(rst2), .en(en), .green_time(green_time), .yellow_time(yellow_time),
        .sensor(sensor2), .emerg_req(emerg_req2), .emerg_road(emerg_road2),
        .allow(allow2), .warn(warn2), .all_red(all_red2), .cur_road(cur_road2),
        .phase_done(phase_done2)
    );

    typedef struct {
        int          dut;
        longint      cyc;
        string       name;
        logic [15:0] allow;
        logic [15:0] warn;
        logic        all_red;
        logic        done;
        logic [3:0]  road;
    } exp_t;

    exp_t   sb[$];
    longint cyc = 0;
    longint base = 0;
    int     n_checks = 0;
    int     n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void snap(input int d, output logic [15:0] a, output logic [15:0] w,
                                 output logic ar, output logic pd, output logic [3:0] rd);
        if (d == 0) begin
            a = 16'(allow); w = 16'(warn); ar = all_red; pd = phase_done; rd = 4'(cur_road);
        end else begin
            a = 16'(allow2); w = 16'(warn2); ar = all_red2; pd = phase_done2; rd = 4'(cur_road2);
        end
    endfunction

    function automatic bit inv_ok(input logic [15:0] a, input logic [15:0] w, input logic ar);
        return ($countones(a | w) <= 1) && !(ar && ((a | w) != 16'h0));
    endfunction

    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] a_allow, a_warn;
        logic        a_ar, a_pd;
        logic [3:0]  a_road;

        n_checks++;
        if (inv_ok(16'(allow), 16'(warn), all_red) && inv_ok(16'(allow2), 16'(warn2), all_red2))
            n_pass++;
        else
            $display("FAIL invariant cyc=%0d: got allow=%h warn=%h all_red=%b / allow2=%h warn2=%h all_red2=%b, required at most one light and all_red exclusive",
                     cyc, allow, warn, all_red, allow2, warn2, all_red2);

        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            snap(e.dut, a_allow, a_warn, a_ar, a_pd, a_road);
            n_checks++;
            if (e.cyc != cyc) begin
                $display("FAIL %s: sample slot cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
            end else if (a_allow === e.allow && a_warn === e.warn && a_ar === e.all_red &&
                         a_pd === e.done && a_road === e.road) begin
                n_pass++;
            end else begin
                $display("FAIL %s cycle %0d: got allow=%h warn=%h all_red=%b done=%b road=%0d, required allow=%h warn=%h all_red=%b done=%b road=%0d",
                         e.name, cyc - base, a_allow, a_warn, a_ar, a_pd, a_road,
                         e.allow, e.warn, e.all_red, e.done, e.road);
            end
        end
    end

    task automatic push_exp(input int d, input int k, input string nm, input logic [15:0] a,
                            input logic [15:0] w, input logic ar, input logic pd,
                            input logic [3:0] rd);
        exp_t e;
        e.dut = d; e.cyc = base + k; e.name = nm;
        e.allow = a; e.warn = w; e.all_red = ar; e.done = pd; e.road = rd;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Stepping to cycle k leaves us just after the edge that starts cycle k;
    // inputs changed here are seen by the edge that starts cycle k+1.
    task automatic goto_cycle(input int k);
        while (cyc < base + k) tick(1);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        base = cyc;
    endtask

    task automatic reset_dut6();
        rst2 = 1'b1;
        tick(3);
        rst2 = 1'b0;
        base = cyc;
    endtask

    initial begin
        rst = 1'b1; rst2 = 1'b1; en = 1'b1;
        green_time = 8'd5; yellow_time = 8'd2;
        sensor = 4'hf; emerg_req = 1'b0; emerg_road = 2'd0;
        sensor2 = 6'h0; emerg_req2 = 1'b0; emerg_road2 = 3'd0;
        tick(2);

        // Basic sequence, all sensors set.
        reset_dut();
        push_exp(0, 0,  "reset_c0",   16'h0, 16'h0, 1, 0, 3);
        push_exp(0, 1,  "reset_c1",   16'h0, 16'h0, 1, 0, 3);
        push_exp(0, 2,  "green0_on",  16'h1, 16'h0, 0, 0, 0);
        push_exp(0, 6,  "green0_end", 16'h1, 16'h0, 0, 0, 0);
        push_exp(0, 7,  "yel0_on",    16'h0, 16'h1, 0, 0, 0);
        push_exp(0, 8,  "yel0_end",   16'h0, 16'h1, 0, 0, 0);
        push_exp(0, 9,  "ared_done",  16'h0, 16'h0, 1, 1, 0);
        push_exp(0, 10, "ared_c10",   16'h0, 16'h0, 1, 0, 0);
        push_exp(0, 11, "green1_on",  16'h2, 16'h0, 0, 0, 1);
        push_exp(0, 20, "green2_on",  16'h4, 16'h0, 0, 0, 2);
        push_exp(0, 29, "green3_on",  16'h8, 16'h0, 0, 0, 3);
        push_exp(0, 38, "green0_wrap", 16'h1, 16'h0, 0, 0, 0);
        goto_cycle(39);

        // Sparse sensors skip idle roads.
        sensor = 4'b1001;
        reset_dut();
        push_exp(0, 2,  "skip_r0",  16'h1, 16'h0, 0, 0, 0);
        push_exp(0, 11, "skip_r3",  16'h8, 16'h0, 0, 0, 3);
        push_exp(0, 20, "skip_r0b", 16'h1, 16'h0, 0, 0, 0);
        push_exp(0, 29, "skip_r3b", 16'h8, 16'h0, 0, 0, 3);
        goto_cycle(30);

        // No sensors: plain rotation.
        sensor = 4'b0000;
        reset_dut();
        push_exp(0, 2,  "rot_r0", 16'h1, 16'h0, 0, 0, 0);
        push_exp(0, 11, "rot_r1", 16'h2, 16'h0, 0, 0, 1);
        push_exp(0, 20, "rot_r2", 16'h4, 16'h0, 0, 0, 2);
        push_exp(0, 29, "rot_r3", 16'h8, 16'h0, 0, 0, 3);
        goto_cycle(30);

        // Emergency for road 2 during road 0 green, held 20 cycles.
        sensor = 4'hf;
        reset_dut();
        push_exp(0, 2, "em_green0", 16'h1, 16'h0, 0, 0, 0);
        goto_cycle(3);
        emerg_req = 1'b1; emerg_road = 2'd2;
        push_exp(0, 3,  "em_req_cyc",   16'h1, 16'h0, 0, 0, 0);
        push_exp(0, 4,  "em_trunc_y",   16'h0, 16'h1, 0, 0, 0);
        push_exp(0, 5,  "em_y_full",    16'h0, 16'h1, 0, 0, 0);
        push_exp(0, 6,  "em_ared",      16'h0, 16'h0, 1, 1, 0);
        push_exp(0, 7,  "em_ared2",     16'h0, 16'h0, 1, 0, 0);
        push_exp(0, 8,  "em_green2",    16'h4, 16'h0, 0, 0, 2);
        push_exp(0, 20, "em_hold",      16'h4, 16'h0, 0, 0, 2);
        goto_cycle(23);
        emerg_req = 1'b0;
        push_exp(0, 27, "em_resume_end", 16'h4, 16'h0, 0, 0, 2);
        push_exp(0, 28, "em_resume_y",   16'h0, 16'h4, 0, 0, 2);
        push_exp(0, 30, "em_done",       16'h0, 16'h0, 1, 1, 2);
        push_exp(0, 32, "em_next_r3",    16'h8, 16'h0, 0, 0, 3);
        goto_cycle(33);

        // Zero durations clamp to a single cycle.
        green_time = 8'd0; yellow_time = 8'd0;
        reset_dut();
        push_exp(0, 2, "zero_green", 16'h1, 16'h0, 0, 0, 0);
        push_exp(0, 3, "zero_yel",   16'h0, 16'h1, 0, 0, 0);
        push_exp(0, 4, "zero_ared",  16'h0, 16'h0, 1, 1, 0);
        push_exp(0, 5, "zero_ared2", 16'h0, 16'h0, 1, 0, 0);
        push_exp(0, 6, "zero_next",  16'h2, 16'h0, 0, 0, 1);
        goto_cycle(7);

        // Enable low for 10 cycles mid-green, then 3 cycles while phase_done is high.
        green_time = 8'd5; yellow_time = 8'd2;
        reset_dut();
        push_exp(0, 2, "en_green_on", 16'h1, 16'h0, 0, 0, 0);
        goto_cycle(3);
        en = 1'b0;
        push_exp(0, 8,  "en_frozen_a", 16'h1, 16'h0, 0, 0, 0);
        push_exp(0, 12, "en_frozen_b", 16'h1, 16'h0, 0, 0, 0);
        goto_cycle(13);
        en = 1'b1;
        push_exp(0, 16, "en_green_ext", 16'h1, 16'h0, 0, 0, 0);
        push_exp(0, 17, "en_yel_on",    16'h0, 16'h1, 0, 0, 0);
        push_exp(0, 18, "en_yel_end",   16'h0, 16'h1, 0, 0, 0);
        push_exp(0, 19, "en_done_on",   16'h0, 16'h0, 1, 1, 0);
        goto_cycle(19);
        en = 1'b0;
        push_exp(0, 21, "en_done_held", 16'h0, 16'h0, 1, 1, 0);
        push_exp(0, 22, "en_done_held2", 16'h0, 16'h0, 1, 1, 0);
        goto_cycle(22);
        en = 1'b1;
        push_exp(0, 23, "en_done_off", 16'h0, 16'h0, 1, 0, 0);
        push_exp(0, 24, "en_next_r1",  16'h2, 16'h0, 0, 0, 1);
        goto_cycle(25);

        // Reset in the middle of yellow.
        reset_dut();
        push_exp(0, 7, "mid_yel", 16'h0, 16'h1, 0, 0, 0);
        goto_cycle(7);
        rst = 1'b1;
        push_exp(0, 8, "rst_mid_yel",  16'h0, 16'h0, 1, 0, 3);
        push_exp(0, 9, "rst_mid_hold", 16'h0, 16'h0, 1, 0, 3);
        goto_cycle(10);

        // N=6: road 5 is a valid emergency target, road 6 is ignored.
        green_time = 8'd3; yellow_time = 8'd1;
        sensor2 = 6'h0; emerg_req2 = 1'b1; emerg_road2 = 3'd5;
        reset_dut6();
        push_exp(1, 0, "n6_reset",    16'h0,  16'h0, 1, 0, 5);
        push_exp(1, 2, "n6_emerg5",   16'h20, 16'h0, 0, 0, 5);
        goto_cycle(2);
        emerg_road2 = 3'd6;
        push_exp(1, 3, "n6_ign6_a",   16'h20, 16'h0,  0, 0, 5);
        push_exp(1, 4, "n6_ign6_b",   16'h20, 16'h0,  0, 0, 5);
        push_exp(1, 5, "n6_yel",      16'h0,  16'h20, 0, 0, 5);
        push_exp(1, 6, "n6_done",     16'h0,  16'h0,  1, 1, 5);
        push_exp(1, 8, "n6_rot_r0",   16'h1,  16'h0,  0, 0, 0);
        goto_cycle(9);

        tick(2);
        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            n_checks++;
            $display("FAIL %s: expected slot at cycle %0d never sampled", e.name, e.cyc - base);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
